// File: rtl/muldiv_sched.sv
// Shares one multi-cycle muldiv unit between two issue ports: round-robin grant,
// operands held for the op latency, result handed to writeback over valid/ready.
module muldiv_sched #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TYPE_W  = 4,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN-1:0]   req0_src1,
    input  logic [XLEN-1:0]   req0_src2,
    input  logic [TYPE_W-1:0] req0_type,
    input  logic              req0_is_div,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN-1:0]   req1_src1,
    input  logic [XLEN-1:0]   req1_src2,
    input  logic [TYPE_W-1:0] req1_type,
    input  logic              req1_is_div,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              mdu_valid,
    output logic [XLEN-1:0]   mdu_src1,
    output logic [XLEN-1:0]   mdu_src2,
    output logic [TYPE_W-1:0] mdu_type,
    input  logic [XLEN-1:0]   mdu_result,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_result,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              wb_src,
    input  logic              flush,
    output logic              busy
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               rr_ptr;
    logic               grant;
    logic               grant_port;
    logic               sel_div;
    logic               lat_port;
    logic [TAG_W-1:0]   lat_tag;
    logic [CNT_W-1:0]   cnt;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and grant; flush suppresses any grant and forces IDLE
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        grant      = 1'b0;
        grant_port = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    if (req0_valid && (!req1_valid || !rr_ptr)) begin
                        req0_ready = 1'b1;
                        grant      = 1'b1;
                    end else if (req1_valid) begin
                        req1_ready = 1'b1;
                        grant      = 1'b1;
                        grant_port = 1'b1;
                    end
                    if (grant) state_next = BUSY;
                end
            end
            BUSY:    if (cnt == '0) state_next = DONE;
            DONE:    if (wb_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    assign sel_div = grant_port ? req1_is_div : req0_is_div;

    // Operand latch, latency counter, result capture and registered status
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= 1'b0;
            lat_port  <= 1'b0;
            lat_tag   <= '0;
            cnt       <= '0;
            mdu_src1  <= '0;
            mdu_src2  <= '0;
            mdu_type  <= '0;
            wb_result <= '0;
            wb_tag    <= '0;
            wb_src    <= 1'b0;
            mdu_valid <= 1'b0;
            wb_valid  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (grant) begin
                mdu_src1 <= grant_port ? req1_src1 : req0_src1;
                mdu_src2 <= grant_port ? req1_src2 : req0_src2;
                mdu_type <= grant_port ? req1_type : req0_type;
                lat_tag  <= grant_port ? req1_tag  : req0_tag;
                lat_port <= grant_port;
                rr_ptr   <= ~grant_port;
                cnt      <= sel_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            end else if (state == BUSY && !flush) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else begin
                    wb_result <= mdu_result;
                    wb_tag    <= lat_tag;
                    wb_src    <= lat_port;
                end
            end
            mdu_valid <= (state_next == BUSY);
            wb_valid  <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: inputs driven and outputs sampled on the falling edge.
module tb_muldiv_sched;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned TYPE_W = 4;
    localparam int unsigned TAG_W  = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, req0_is_div;
    logic [XLEN-1:0]   req0_src1, req0_src2;
    logic [TYPE_W-1:0] req0_type;
    logic [TAG_W-1:0]  req0_tag;
    logic              req1_valid, req1_ready, req1_is_div;
    logic [XLEN-1:0]   req1_src1, req1_src2;
    logic [TYPE_W-1:0] req1_type;
    logic [TAG_W-1:0]  req1_tag;
    logic              mdu_valid;
    logic [XLEN-1:0]   mdu_src1, mdu_src2, mdu_result;
    logic [TYPE_W-1:0] mdu_type;
    logic              wb_valid, wb_ready, wb_src, flush, busy;
    logic [XLEN-1:0]   wb_result;
    logic [TAG_W-1:0]  wb_tag;

    int nchk = 0;
    int nfail = 0;

    always #5 clock = ~clock;

    muldiv_sched dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src1(req0_src1),
        .req0_src2(req0_src2), .req0_type(req0_type), .req0_is_div(req0_is_div),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src1(req1_src1),
        .req1_src2(req1_src2), .req1_type(req1_type), .req1_is_div(req1_is_div),
        .req1_tag(req1_tag),
        .mdu_valid(mdu_valid), .mdu_src1(mdu_src1), .mdu_src2(mdu_src2),
        .mdu_type(mdu_type), .mdu_result(mdu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_tag(wb_tag), .wb_src(wb_src), .flush(flush), .busy(busy)
    );

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; wb_ready = 1'b1; mdu_result = '0;
        req0_valid = 1'b0; req0_src1 = '0; req0_src2 = '0; req0_type = '0; req0_is_div = 1'b0; req0_tag = '0;
        req1_valid = 1'b0; req1_src1 = '0; req1_src2 = '0; req1_type = '0; req1_is_div = 1'b0; req1_tag = '0;
        @(negedge clock);
        step();
        reset = 1'b0;
        #1;
        nchk++; if (mdu_valid !== 1'b0) begin nfail++; $display("FAIL reset_mdu_valid got %0b exp 0", mdu_valid); end
        nchk++; if (wb_valid !== 1'b0) begin nfail++; $display("FAIL reset_wb_valid got %0b exp 0", wb_valid); end
        nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %0b exp 0", busy); end
        nchk++; if ({mdu_src1, mdu_src2, mdu_type} !== '0) begin nfail++; $display("FAIL reset_mdu_data got %0h exp 0", mdu_src1); end
        nchk++; if ({wb_result, wb_tag, wb_src} !== '0) begin nfail++; $display("FAIL reset_wb_data got %0h exp 0", wb_result); end
        nchk++; if ({req0_ready, req1_ready} !== 2'b00) begin nfail++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
    endtask

    task automatic test_single_mul();
        wb_ready = 1'b1; mdu_result = 64'd42;
        req0_valid = 1'b1; req0_src1 = 64'd7; req0_src2 = 64'd6; req0_type = 4'd2; req0_is_div = 1'b0; req0_tag = 5'd3;
        #1;
        nchk++; if ({req0_ready, req1_ready} !== 2'b10) begin nfail++; $display("FAIL mul_grant got %b exp 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            nchk++; if ({mdu_valid, wb_valid, busy} !== 3'b101) begin nfail++; $display("FAIL mul_busy_c%0d got %b exp 101", k, {mdu_valid, wb_valid, busy}); end
            nchk++; if ({mdu_src1, mdu_src2, mdu_type} !== {64'd7, 64'd6, 4'd2}) begin nfail++; $display("FAIL mul_operands_c%0d got %0h/%0h/%0h exp 7/6/2", k, mdu_src1, mdu_src2, mdu_type); end
            step();
        end
        nchk++; if ({mdu_valid, wb_valid} !== 2'b01) begin nfail++; $display("FAIL mul_done_valid got %b exp 01", {mdu_valid, wb_valid}); end
        nchk++; if (wb_result !== 64'd42) begin nfail++; $display("FAIL mul_wb_result got %0d exp 42", wb_result); end
        nchk++; if ({wb_tag, wb_src} !== {5'd3, 1'b0}) begin nfail++; $display("FAIL mul_wb_tag_src got %0d/%0b exp 3/0", wb_tag, wb_src); end
        step();
        nchk++; if ({busy, wb_valid} !== 2'b00) begin nfail++; $display("FAIL mul_idle got %b exp 00", {busy, wb_valid}); end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset = 1'b0; wb_ready = 1'b1; mdu_result = 64'h55;
        req0_valid = 1'b1; req0_is_div = 1'b0; req0_tag = 5'd1;
        req1_valid = 1'b1; req1_is_div = 1'b0; req1_tag = 5'd2;
        for (int g = 0; g < 4; g++) begin
            #1;
            nchk++; if ({req0_ready, req1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin
                nfail++; $display("FAIL rr_grant%0d got %b exp %s", g, {req0_ready, req1_ready}, (g % 2 == 0) ? "10" : "01");
            end
            if (g == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            step();
            for (int k = 0; k < 4; k++) begin
                nchk++; if ({req0_ready, req1_ready} !== 2'b00) begin nfail++; $display("FAIL rr_hold%0d_%0d got %b exp 00", g, k, {req0_ready, req1_ready}); end
                step();
            end
        end
        nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL rr_final_idle got %0b exp 0", busy); end
    endtask

    task automatic test_divide();
        wb_ready = 1'b1; mdu_result = 64'd14;
        req1_valid = 1'b1; req1_src1 = 64'd100; req1_src2 = 64'd7; req1_type = 4'd4; req1_is_div = 1'b1; req1_tag = 5'd17;
        #1;
        nchk++; if ({req0_ready, req1_ready} !== 2'b01) begin nfail++; $display("FAIL div_grant got %b exp 01", {req0_ready, req1_ready}); end
        step();
        req1_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            nchk++; if ({mdu_valid, mdu_src1, mdu_src2, mdu_type} !== {1'b1, 64'd100, 64'd7, 4'd4}) begin
                nfail++; $display("FAIL div_hold_c%0d got v=%0b %0d/%0d exp v=1 100/7", k, mdu_valid, mdu_src1, mdu_src2);
            end
            step();
        end
        nchk++; if ({mdu_valid, wb_valid} !== 2'b01) begin nfail++; $display("FAIL div_done got %b exp 01", {mdu_valid, wb_valid}); end
        nchk++; if ({wb_result, wb_tag, wb_src} !== {64'd14, 5'd17, 1'b1}) begin nfail++; $display("FAIL div_wb got %0d/%0d/%0b exp 14/17/1", wb_result, wb_tag, wb_src); end
        step();
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0; mdu_result = 64'd15;
        req0_valid = 1'b1; req0_src1 = 64'd3; req0_src2 = 64'd5; req0_is_div = 1'b0; req0_tag = 5'd9;
        step();
        req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        mdu_result = 64'hDEAD;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            nchk++; if ({wb_valid, wb_result, wb_tag} !== {1'b1, 64'd15, 5'd9}) begin
                nfail++; $display("FAIL bp_hold_c%0d got v=%0b %0d/%0d exp v=1 15/9", k, wb_valid, wb_result, wb_tag);
            end
            nchk++; if ({req0_ready, req1_ready} !== 2'b00) begin nfail++; $display("FAIL bp_no_grant_c%0d got %b exp 00", k, {req0_ready, req1_ready}); end
            step();
        end
        wb_ready = 1'b1;
        #1;
        nchk++; if ({req0_ready, req1_ready, wb_valid} !== 3'b001) begin nfail++; $display("FAIL bp_release got %b exp 001", {req0_ready, req1_ready, wb_valid}); end
        req1_valid = 1'b0;
        step();
        nchk++; if ({busy, wb_valid} !== 2'b00) begin nfail++; $display("FAIL bp_idle got %b exp 00", {busy, wb_valid}); end
    endtask

    task automatic test_flush();
        wb_ready = 1'b1; mdu_result = 64'd99;
        req0_valid = 1'b1; req0_src1 = 64'd11; req0_src2 = 64'd9; req0_tag = 5'd5; req0_is_div = 1'b0;
        step();
        req0_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        nchk++; if ({mdu_valid, busy, wb_valid} !== 3'b000) begin nfail++; $display("FAIL flush_cancel got %b exp 000", {mdu_valid, busy, wb_valid}); end
        for (int k = 0; k < 6; k++) begin
            nchk++; if (wb_valid !== 1'b0) begin nfail++; $display("FAIL flush_no_wb_c%0d got %0b exp 0", k, wb_valid); end
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1; flush = 1'b1;
        #1;
        nchk++; if ({req0_ready, req1_ready} !== 2'b00) begin nfail++; $display("FAIL flush_idle_no_grant got %b exp 00", {req0_ready, req1_ready}); end
        step();
        flush = 1'b0;
        #1;
        nchk++; if ({req0_ready, req1_ready} !== 2'b01) begin nfail++; $display("FAIL flush_rr_kept got %b exp 01", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_reset_mid_done();
        wb_ready = 1'b0; mdu_result = 64'h1234;
        req0_valid = 1'b1; req0_src1 = 64'd8; req0_src2 = 64'd8; req0_type = 4'd3; req0_tag = 5'd21; req0_is_div = 1'b0;
        step();
        req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        nchk++; if (wb_valid !== 1'b1) begin nfail++; $display("FAIL rstdone_pre got %0b exp 1", wb_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        nchk++; if ({mdu_valid, wb_valid, busy, wb_src} !== 4'b0000) begin nfail++; $display("FAIL rstdone_flags got %b exp 0000", {mdu_valid, wb_valid, busy, wb_src}); end
        nchk++; if ({wb_result, wb_tag, mdu_src1, mdu_src2, mdu_type} !== '0) begin nfail++; $display("FAIL rstdone_data got %0h/%0d exp 0/0", wb_result, wb_tag); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        nchk++; if ({req0_ready, req1_ready} !== 2'b10) begin nfail++; $display("FAIL rstdone_regrant got %b exp 10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_mul();
        test_back_to_back();
        test_divide();
        test_backpressure();
        test_flush();
        test_reset_mid_done();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
